relu_argmax_stage: RTL and testbench

//  Post-matmul stage downstream of the BRAM matrix-multiply engine. After that engine finishes, this block streams
//  the M x N FP32 result matrix C out of its BRAM, one element per cycle. It optionally applies ReLU and writes each

---
 rtl/relu_argmax_stage_pkg.sv | 31 +++
 rtl/relu_argmax_stage_if.sv | 43 ++++
 rtl/relu_argmax_stage_fp32_max_tracker.sv | 47 ++++
 rtl/relu_argmax_stage.sv | 218 +++++++++++++++++++++
 tb/tb_relu_argmax_stage.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/relu_argmax_stage_pkg.sv
// Shared definitions for the post-matmul stage (also used by the matmul engine).
//   FP32_W      : width of an FP32 word
//   fp32_t      : FP32 bit pattern
//   state_e     : controller states
//   fp32_key    : maps FP32 bits to an unsigned key whose order matches FP32 order
//   fp32_relu   : optional ReLU on FP32 bits
package relu_argmax_stage_pkg;

  localparam int FP32_W = 32;

  typedef logic [FP32_W-1:0] fp32_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Negative values are inverted so larger magnitudes sort lower; positives get
  // the top bit set so every positive (including +0) beats every negative (-0).
  function automatic fp32_t fp32_key(input fp32_t x);
    return x[FP32_W-1] ? ~x : {1'b1, x[FP32_W-2:0]};
  endfunction

  // Any value with the sign bit set (including -0.0 and negative NaNs) becomes +0.0.
  function automatic fp32_t fp32_relu(input fp32_t x, input logic en);
    return (en && x[FP32_W-1]) ? '0 : x;
  endfunction

endpackage

// File: rtl/relu_argmax_stage_if.sv
// Bus bundle for relu_argmax_stage: control, C BRAM read port, activation BRAM
// write port and per-row argmax results.
//   slave  : view of relu_argmax_stage itself
//   master : view of the controller / BRAMs / result consumer
interface relu_argmax_stage_if
  import relu_argmax_stage_pkg::*;
#(
  parameter int MAX_M = 16,
  parameter int MAX_N = 16
);
  localparam int ADDR_M_BITS = $clog2(MAX_M);
  localparam int ADDR_N_BITS = $clog2(MAX_N);
  localparam int ADDR_C_BITS = $clog2(MAX_M * MAX_N);

  logic                   start;
  logic                   relu_en;
  logic [ADDR_M_BITS:0]   M_val;
  logic [ADDR_N_BITS:0]   N_val;
  logic                   busy;
  logic                   done;
  logic [ADDR_C_BITS-1:0] c_addr;
  fp32_t                  c_rdata;
  logic                   act_we;
  logic [ADDR_C_BITS-1:0] act_addr;
  fp32_t                  act_wdata;
  logic                   row_valid;
  logic [ADDR_M_BITS-1:0] row_idx;
  logic [ADDR_N_BITS-1:0] row_argmax;
  fp32_t                  row_max;

  modport slave (
    input  start, relu_en, M_val, N_val, c_rdata,
    output busy, done, c_addr, act_we, act_addr, act_wdata,
           row_valid, row_idx, row_argmax, row_max
  );

  modport master (
    output start, relu_en, M_val, N_val, c_rdata,
    input  busy, done, c_addr, act_we, act_addr, act_wdata,
           row_valid, row_idx, row_argmax, row_max
  );

endinterface

// File: rtl/relu_argmax_stage_fp32_max_tracker.sv
// Running FP32 maximum for one row.
//   clk, rst : clock, async active-high reset
//   seed     : current element is column 0 and starts a new row
//   update   : current element is valid; commit the result to the running max
//   idx_in   : column of current element
//   val_in   : value of current element
//   res_idx  : column of the max including the current element (combinational)
//   res_val  : max value including the current element (combinational)
module fp32_max_tracker
  import relu_argmax_stage_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed,
  input  logic             update,
  input  logic [IDX_W-1:0] idx_in,
  input  fp32_t            val_in,
  output logic [IDX_W-1:0] res_idx,
  output fp32_t            res_val
);

  logic [IDX_W-1:0] max_idx_q, max_idx_d;
  fp32_t            max_val_q, max_val_d;
  logic             take;

  always_comb begin
    // Strictly greater replaces, so ties keep the earliest column.
    take      = seed || (fp32_key(val_in) > fp32_key(max_val_q));
    res_idx   = take ? idx_in : max_idx_q;
    res_val   = take ? val_in : max_val_q;
    max_idx_d = update ? res_idx : max_idx_q;
    max_val_d = update ? res_val : max_val_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_idx_q <= '0;
      max_val_q <= '0;
    end else begin
      max_idx_q <= max_idx_d;
      max_val_q <= max_val_d;
    end
  end

endmodule

// File: rtl/relu_argmax_stage.sv
// Post-matmul stage: streams the M x N FP32 matrix C from its BRAM, optionally
// applies ReLU, writes every element to the activation BRAM and reports the
// argmax column / max value of each row.
//   clk, rst : clock, async active-high reset
//   bus      : relu_argmax_stage_if.slave
//              start/relu_en/M_val/N_val in, busy/done out,
//              c_addr out / c_rdata in (1-cycle read latency),
//              act_we/act_addr/act_wdata out,
//              row_valid/row_idx/row_argmax/row_max out
// Pipeline: address issued in cycle t, data back in t+1, write/row result in t+2.
module relu_argmax_stage
  import relu_argmax_stage_pkg::*;
#(
  parameter int MAX_M = 16,
  parameter int MAX_N = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  relu_argmax_stage_if.slave    bus
);

  localparam int ADDR_M_BITS = $clog2(MAX_M);
  localparam int ADDR_N_BITS = $clog2(MAX_N);
  localparam int ADDR_C_BITS = $clog2(MAX_M * MAX_N);

  localparam logic [ADDR_M_BITS:0]   M_ONE   = 1;
  localparam logic [ADDR_N_BITS:0]   N_ONE   = 1;
  localparam logic [ADDR_M_BITS-1:0] ROW_ONE = 1;
  localparam logic [ADDR_N_BITS-1:0] COL_ONE = 1;
  localparam logic [ADDR_C_BITS-1:0] C_ONE   = 1;

  typedef struct packed {
    logic                   valid;
    logic [ADDR_M_BITS-1:0] row;
    logic [ADDR_N_BITS-1:0] col;
    logic                   last_col;
    logic                   last;
    logic [ADDR_C_BITS-1:0] addr;
  } tag_t;

  state_e                 state_q, state_d;
  logic [ADDR_M_BITS:0]   m_q, m_d;
  logic [ADDR_N_BITS:0]   n_q, n_d;
  logic                   relu_q, relu_d;
  logic [ADDR_M_BITS-1:0] rd_row_q, rd_row_d;
  logic [ADDR_N_BITS-1:0] rd_col_q, rd_col_d;
  logic [ADDR_C_BITS-1:0] c_addr_q, c_addr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  tag_t                   s1_q, s1_d;
  logic                   act_we_q, act_we_d;
  logic [ADDR_C_BITS-1:0] act_addr_q, act_addr_d;
  fp32_t                  act_wdata_q, act_wdata_d;
  logic                   s2_last_q, s2_last_d;
  logic                   row_valid_q, row_valid_d;
  logic [ADDR_M_BITS-1:0] row_idx_q, row_idx_d;
  logic [ADDR_N_BITS-1:0] row_argmax_q, row_argmax_d;
  fp32_t                  row_max_q, row_max_d;

  logic                   issue_last_col;
  logic                   issue_last_row;
  fp32_t                  relu_val;
  logic [ADDR_N_BITS-1:0] trk_idx;
  fp32_t                  trk_val;

  assign issue_last_col = ({1'b0, rd_col_q} == (n_q - N_ONE));
  assign issue_last_row = ({1'b0, rd_row_q} == (m_q - M_ONE));
  assign relu_val       = fp32_relu(bus.c_rdata, relu_q);

  fp32_max_tracker #(
    .IDX_W (ADDR_N_BITS)
  ) u_max (
    .clk     (clk),
    .rst     (rst),
    .seed    (s1_q.valid && (s1_q.col == '0)),
    .update  (s1_q.valid),
    .idx_in  (s1_q.col),
    .val_in  (relu_val),
    .res_idx (trk_idx),
    .res_val (trk_val)
  );

  always_comb begin
    state_d      = state_q;
    m_d          = m_q;
    n_d          = n_q;
    relu_d       = relu_q;
    rd_row_d     = rd_row_q;
    rd_col_d     = rd_col_q;
    c_addr_d     = c_addr_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    // Tag for the address presented this cycle; valid only while reading.
    s1_d.valid    = (state_q == ST_READ);
    s1_d.row      = rd_row_q;
    s1_d.col      = rd_col_q;
    s1_d.last_col = issue_last_col;
    s1_d.last     = issue_last_col && issue_last_row;
    s1_d.addr     = c_addr_q;

    act_we_d     = s1_q.valid;
    act_addr_d   = s1_q.valid ? s1_q.addr : act_addr_q;
    act_wdata_d  = s1_q.valid ? relu_val : act_wdata_q;
    s2_last_d    = s1_q.valid && s1_q.last;

    row_valid_d  = s1_q.valid && s1_q.last_col;
    row_idx_d    = row_idx_q;
    row_argmax_d = row_argmax_q;
    row_max_d    = row_max_q;
    if (row_valid_d) begin
      row_idx_d    = s1_q.row;
      row_argmax_d = trk_idx;
      row_max_d    = trk_val;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if ((bus.M_val != '0) && (bus.N_val != '0)) begin
            state_d  = ST_READ;
            m_d      = bus.M_val;
            n_d      = bus.N_val;
            relu_d   = bus.relu_en;
            rd_row_d = '0;
            rd_col_d = '0;
            c_addr_d = '0;
            busy_d   = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_READ: begin
        // Row-major order makes row*N+col a plain running count, so the
        // address is incremented instead of multiplied.
        if (issue_last_col) begin
          rd_col_d = '0;
          if (issue_last_row) begin
            state_d = ST_DRAIN;
          end else begin
            rd_row_d = rd_row_q + ROW_ONE;
            c_addr_d = c_addr_q + C_ONE;
          end
        end else begin
          rd_col_d = rd_col_q + COL_ONE;
          c_addr_d = c_addr_q + C_ONE;
        end
      end
      ST_DRAIN: begin
        if (s2_last_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      m_q          <= '0;
      n_q          <= '0;
      relu_q       <= 1'b0;
      rd_row_q     <= '0;
      rd_col_q     <= '0;
      c_addr_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      s1_q         <= '0;
      act_we_q     <= 1'b0;
      act_addr_q   <= '0;
      act_wdata_q  <= '0;
      s2_last_q    <= 1'b0;
      row_valid_q  <= 1'b0;
      row_idx_q    <= '0;
      row_argmax_q <= '0;
      row_max_q    <= '0;
    end else begin
      state_q      <= state_d;
      m_q          <= m_d;
      n_q          <= n_d;
      relu_q       <= relu_d;
      rd_row_q     <= rd_row_d;
      rd_col_q     <= rd_col_d;
      c_addr_q     <= c_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      s1_q         <= s1_d;
      act_we_q     <= act_we_d;
      act_addr_q   <= act_addr_d;
      act_wdata_q  <= act_wdata_d;
      s2_last_q    <= s2_last_d;
      row_valid_q  <= row_valid_d;
      row_idx_q    <= row_idx_d;
      row_argmax_q <= row_argmax_d;
      row_max_q    <= row_max_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.c_addr     = c_addr_q;
  assign bus.act_we     = act_we_q;
  assign bus.act_addr   = act_addr_q;
  assign bus.act_wdata  = act_wdata_q;
  assign bus.row_valid  = row_valid_q;
  assign bus.row_idx    = row_idx_q;
  assign bus.row_argmax = row_argmax_q;
  assign bus.row_max    = row_max_q;

endmodule

// File: tb/tb_relu_argmax_stage.sv
module tb_relu_argmax_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  relu_argmax_stage_if #(.MAX_M(16), .MAX_N(16)) bif ();

  relu_argmax_stage #(.MAX_M(16), .MAX_N(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  // C BRAM model: one-cycle read latency.
  logic [31:0] cmem [256];
  always @(posedge clk) bif.c_rdata <= cmem[bif.c_addr];

  int n_cmp = 0;
  int n_bad = 0;

  // Records of the most recent pass (written only by the initial-block tasks).
  logic [31:0] act_mem [256];
  int          act_cnt, first_we, done_rel, done_cnt, row_n;
  logic        busy1, busy_done;
  int          r_idx [16];
  int          r_arg [16];
  logic [31:0] r_max [16];

  localparam logic [31:0] P1 = 32'h3F80_0000, P2 = 32'h4000_0000, P3 = 32'h4040_0000;
  localparam logic [31:0] N1 = 32'hBF80_0000, N5 = 32'hC0A0_0000, NH = 32'hBF00_0000;
  localparam logic [31:0] PZ = 32'h0000_0000, NZ = 32'h8000_0000;

  task automatic run_pass(input int m, input int n, input logic relu,
                          input int pulse_at, input int budget);
    act_cnt = 0; first_we = -1; done_rel = -1; done_cnt = 0; row_n = 0;
    busy1 = 1'b0; busy_done = 1'b1;
    for (int k = 0; k < 256; k++) act_mem[k] = 32'hDEAD_BEEF;
    @(negedge clk);
    bif.start = 1'b1; bif.relu_en = relu;
    bif.M_val = 5'(m); bif.N_val = 5'(n);
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      bif.start = (i == pulse_at);
      if (i == 1) busy1 = bif.busy;
      if (bif.act_we) begin
        act_mem[bif.act_addr] = bif.act_wdata;
        act_cnt++;
        if (first_we < 0) first_we = i;
      end
      if (bif.row_valid && row_n < 16) begin
        r_idx[row_n] = int'(bif.row_idx);
        r_arg[row_n] = int'(bif.row_argmax);
        r_max[row_n] = bif.row_max;
        row_n++;
      end
      if (bif.done) begin
        done_cnt++;
        if (done_rel < 0) begin done_rel = i; busy_done = bif.busy; end
      end
      if (done_rel >= 0 && i >= done_rel + 3) break;
    end
    bif.start = 1'b0;
  endtask

  task automatic load_2x3();
    cmem[0] = P1; cmem[1] = P3; cmem[2] = P2;
    cmem[3] = N1; cmem[4] = N5; cmem[5] = NH;
  endtask

  task automatic test_reset();
    bif.start = 1'b0; bif.relu_en = 1'b0; bif.M_val = '0; bif.N_val = '0;
    #1;
    n_cmp++; if ({bif.busy, bif.done, bif.act_we, bif.row_valid} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_ctrl got %b want 0000", {bif.busy, bif.done, bif.act_we, bif.row_valid}); end
    n_cmp++; if ({bif.c_addr, bif.act_addr, bif.act_wdata, bif.row_max} !== '0) begin
      n_bad++; $display("FAIL reset_data c_addr=%h act_addr=%h wdata=%h max=%h", bif.c_addr, bif.act_addr, bif.act_wdata, bif.row_max); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] exp_c [6];
    exp_c = '{P1, P3, P2, N1, N5, NH};
    load_2x3();
    run_pass(2, 3, 1'b0, 0, 40);
    n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL basic_busy got %b want 1", busy1); end
    n_cmp++; if (first_we !== 3) begin n_bad++; $display("FAIL basic_latency got %0d want 3", first_we); end
    n_cmp++; if (done_rel !== 9) begin n_bad++; $display("FAIL basic_done_cycle got %0d want 9", done_rel); end
    n_cmp++; if (busy_done !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done got %b want 0", busy_done); end
    n_cmp++; if (act_cnt !== 6) begin n_bad++; $display("FAIL basic_act_cnt got %0d want 6", act_cnt); end
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (act_mem[k] !== exp_c[k]) begin
        n_bad++; $display("FAIL basic_act[%0d] got %h want %h", k, act_mem[k], exp_c[k]); end
    end
    n_cmp++; if (row_n !== 2) begin n_bad++; $display("FAIL basic_rows got %0d want 2", row_n); end
    n_cmp++; if (r_idx[0] !== 0 || r_arg[0] !== 1 || r_max[0] !== P3) begin
      n_bad++; $display("FAIL basic_row0 got (%0d,%0d,%h) want (0,1,%h)", r_idx[0], r_arg[0], r_max[0], P3); end
    n_cmp++; if (r_idx[1] !== 1 || r_arg[1] !== 2 || r_max[1] !== NH) begin
      n_bad++; $display("FAIL basic_row1 got (%0d,%0d,%h) want (1,2,%h)", r_idx[1], r_arg[1], r_max[1], NH); end
  endtask

  task automatic test_relu();
    logic [31:0] exp_c [6];
    exp_c = '{P1, P3, P2, PZ, PZ, PZ};
    load_2x3();
    run_pass(2, 3, 1'b1, 0, 40);
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (act_mem[k] !== exp_c[k]) begin
        n_bad++; $display("FAIL relu_act[%0d] got %h want %h", k, act_mem[k], exp_c[k]); end
    end
    n_cmp++; if (r_arg[0] !== 1 || r_max[0] !== P3) begin
      n_bad++; $display("FAIL relu_row0 got (%0d,%h) want (1,%h)", r_arg[0], r_max[0], P3); end
    n_cmp++; if (r_idx[1] !== 1 || r_arg[1] !== 0 || r_max[1] !== PZ) begin
      n_bad++; $display("FAIL relu_row1 got (%0d,%0d,%h) want (1,0,0)", r_idx[1], r_arg[1], r_max[1]); end
  endtask

  task automatic test_ties();
    cmem[0] = P2; cmem[1] = P2; cmem[2] = NZ; cmem[3] = PZ;
    run_pass(1, 4, 1'b0, 0, 40);
    n_cmp++; if (row_n !== 1 || r_arg[0] !== 0 || r_max[0] !== P2) begin
      n_bad++; $display("FAIL tie_equal got n=%0d (%0d,%h) want n=1 (0,%h)", row_n, r_arg[0], r_max[0], P2); end
    n_cmp++; if (done_rel !== 7) begin n_bad++; $display("FAIL tie_done_cycle got %0d want 7", done_rel); end
    cmem[0] = NZ; cmem[1] = PZ;
    run_pass(1, 2, 1'b0, 0, 40);
    n_cmp++; if (row_n !== 1 || r_arg[0] !== 1 || r_max[0] !== PZ) begin
      n_bad++; $display("FAIL tie_zero got n=%0d (%0d,%h) want n=1 (1,0)", row_n, r_arg[0], r_max[0]); end
  endtask

  task automatic test_back_to_back();
    load_2x3();
    run_pass(2, 3, 1'b0, 3, 40);
    n_cmp++; if (act_cnt !== 6 || done_cnt !== 1 || done_rel !== 9) begin
      n_bad++; $display("FAIL b2b_ignored got acts=%0d dones=%0d done@%0d want 6/1/9", act_cnt, done_cnt, done_rel); end
    cmem[0] = N5; cmem[1] = N1; cmem[2] = P2; cmem[3] = P1; cmem[4] = NH; cmem[5] = P3;
    run_pass(3, 2, 1'b0, 0, 40);
    n_cmp++; if (act_cnt !== 6 || done_rel !== 9 || act_mem[5] !== P3 || act_mem[0] !== N5) begin
      n_bad++; $display("FAIL b2b_second got acts=%0d done@%0d a0=%h a5=%h", act_cnt, done_rel, act_mem[0], act_mem[5]); end
    n_cmp++; if (row_n !== 3 || r_arg[0] !== 1 || r_arg[1] !== 0 || r_arg[2] !== 1 || r_max[2] !== P3) begin
      n_bad++; $display("FAIL b2b_rows got n=%0d args=%0d,%0d,%0d max2=%h want 3 1,0,1 %h",
                        row_n, r_arg[0], r_arg[1], r_arg[2], r_max[2], P3); end
  endtask

  task automatic test_zero_dims();
    run_pass(0, 3, 1'b0, 0, 20);
    n_cmp++; if (act_cnt !== 0 || row_n !== 0 || done_rel !== 1 || busy1 !== 1'b0) begin
      n_bad++; $display("FAIL zero_m got acts=%0d rows=%0d done@%0d busy=%b want 0/0/1/0", act_cnt, row_n, done_rel, busy1); end
    run_pass(4, 0, 1'b0, 0, 20);
    n_cmp++; if (act_cnt !== 0 || row_n !== 0 || done_rel !== 1) begin
      n_bad++; $display("FAIL zero_n got acts=%0d rows=%0d done@%0d want 0/0/1", act_cnt, row_n, done_rel); end
  endtask

  task automatic test_reset_mid_pass();
    int we_seen = 0;
    int done_seen = 0;
    for (int k = 0; k < 16; k++) cmem[k] = 32'h4100_0000 + 32'(k);
    @(negedge clk);
    bif.start = 1'b1; bif.relu_en = 1'b0; bif.M_val = 5'd4; bif.N_val = 5'd4;
    @(negedge clk);
    bif.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if ({bif.busy, bif.done, bif.act_we, bif.row_valid} !== 4'b0000
                 || {bif.c_addr, bif.act_addr, bif.act_wdata, bif.row_max, bif.row_argmax, bif.row_idx} !== '0) begin
      n_bad++; $display("FAIL midrst_outputs busy=%b we=%b c_addr=%h act_addr=%h wdata=%h",
                        bif.busy, bif.act_we, bif.c_addr, bif.act_addr, bif.act_wdata); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bif.act_we) we_seen++;
      if (bif.done) done_seen++;
    end
    n_cmp++; if (we_seen !== 0 || done_seen !== 0) begin
      n_bad++; $display("FAIL midrst_quiet got writes=%0d dones=%0d want 0/0", we_seen, done_seen); end
  endtask

  // Sign-magnitude ordering: +0 above -0, positives above negatives.
  function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return !a[31];
    if (!a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  task automatic test_random_16x16();
    logic [31:0] exp_a [256];
    logic [31:0] best, v;
    int          best_c;
    int          bad_act, bad_row;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 256; k++) begin
        cmem[k] = $urandom;
        if (k % 37 == 5) cmem[k] = NZ;
        exp_a[k] = (r == 1 && cmem[k][31]) ? 32'h0 : cmem[k];
      end
      run_pass(16, 16, r[0], 0, 400);
      n_cmp++; if (act_cnt !== 256 || done_rel !== 259) begin
        n_bad++; $display("FAIL rand%0d_count got acts=%0d done@%0d want 256/259", r, act_cnt, done_rel); end
      bad_act = 0;
      for (int k = 0; k < 256; k++) if (act_mem[k] !== exp_a[k]) bad_act++;
      n_cmp++; if (bad_act !== 0) begin
        n_bad++; $display("FAIL rand%0d_act got %0d wrong words want 0", r, bad_act); end
      bad_row = 0;
      for (int row = 0; row < 16; row++) begin
        best = exp_a[row*16]; best_c = 0;
        for (int c = 1; c < 16; c++) begin
          v = exp_a[row*16 + c];
          if (fp_gt(v, best)) begin best = v; best_c = c; end
        end
        if (row >= row_n || r_idx[row] !== row || r_arg[row] !== best_c || r_max[row] !== best) bad_row++;
      end
      n_cmp++; if (row_n !== 16 || bad_row !== 0) begin
        n_bad++; $display("FAIL rand%0d_rows got rows=%0d wrong=%0d want 16/0", r, row_n, bad_row); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_ties();
    test_back_to_back();
    test_zero_dims();
    test_reset_mid_pass();
    test_random_16x16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
